pin_entry_collector: RTL and testbench

//  Keypad front end for the parking gate controller: collects BCD digits, converts them to a

---
 rtl/pin_entry_collector.sv | 157 +++++++++++++++
 tb/tb_pin_entry_collector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_collector.sv
// Keypad front end: collects BCD digits into a binary PIN word and offers it
// to the gate controller over a valid/ready handshake.
module pin_entry_collector #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned PIN_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TO_W           = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_digit,
    input  logic             key_enter,
    input  logic             key_clear,
    input  logic             pin_ready,
    output logic [PIN_W-1:0] pin_value,
    output logic             pin_valid,
    output logic [2:0]       digit_cnt,
    output logic             entry_err
);

    localparam int unsigned MAC_W = PIN_W + 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2,
        PRESENT = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [PIN_W-1:0] acc_q, acc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic [PIN_W-1:0] pin_value_q, pin_value_d;
    logic             pin_valid_q, pin_valid_d;
    logic             err_q, err_d;

    logic             key_any;
    logic             digit_ok;
    logic [2:0]       cnt_inc;
    logic             reach_full;
    logic [MAC_W-1:0] mac;

    assign key_any    = key_valid | key_enter | key_clear;
    assign digit_ok   = (key_digit <= 4'd9);
    assign cnt_inc    = cnt_q + 3'd1;
    assign reach_full = (cnt_inc == 3'(NUM_DIGITS));
    // acc*10 + digit in a wider word, truncated to PIN_W below
    assign mac        = {4'b0000, acc_q} * MAC_W'(10) + MAC_W'(key_digit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            pin_value_q <= '0;
            pin_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            pin_value_q <= pin_value_d;
            pin_valid_q <= pin_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        timer_d     = '0;
        pin_value_d = pin_value_q;
        pin_valid_d = pin_valid_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_clear) begin
                    state_d = IDLE;
                end else if (key_enter) begin
                    err_d = 1'b1;
                end else if (key_valid) begin
                    if (digit_ok) begin
                        acc_d   = mac[PIN_W-1:0];
                        cnt_d   = cnt_inc;
                        state_d = reach_full ? FULL : COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            COLLECT, FULL: begin
                // any key strobe restarts the idle window
                timer_d = key_any ? '0 : timer_q + TO_W'(1);
                if (key_clear) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (key_enter) begin
                    if (state_q == FULL) begin
                        pin_value_d = acc_q;
                        pin_valid_d = 1'b1;
                        state_d     = PRESENT;
                    end else begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (key_valid) begin
                    if (!digit_ok) begin
                        err_d = 1'b1;
                    end else if (state_q == COLLECT) begin
                        acc_d   = mac[PIN_W-1:0];
                        cnt_d   = cnt_inc;
                        state_d = reach_full ? FULL : COLLECT;
                    end
                end else if (timer_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            PRESENT: begin
                // transfer and withdraw leave the same clean state behind
                if (pin_ready || key_clear) begin
                    pin_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE || state_d == PRESENT) begin
            timer_d = '0;
        end
    end

    assign pin_value = pin_value_q;
    assign pin_valid = pin_valid_q;
    assign digit_cnt = cnt_q;
    assign entry_err = err_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed self-checking bench for pin_entry_collector (2 digits, short timeout).
module tb_pin_entry_collector;

    localparam int unsigned NUM_DIGITS     = 2;
    localparam int unsigned PIN_W          = 8;
    localparam int unsigned TIMEOUT_CYCLES = 20;
    localparam int unsigned TO_W           = 5;

    logic             clock;
    logic             reset;
    logic             key_valid;
    logic [3:0]       key_digit;
    logic             key_enter;
    logic             key_clear;
    logic             pin_ready;
    logic [PIN_W-1:0] pin_value;
    logic             pin_valid;
    logic [2:0]       digit_cnt;
    logic             entry_err;

    int total = 0;
    int bad   = 0;

    pin_entry_collector #(
        .NUM_DIGITS    (NUM_DIGITS),
        .PIN_W         (PIN_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .key_enter(key_enter),
        .key_clear(key_clear),
        .pin_ready(pin_ready),
        .pin_value(pin_value),
        .pin_valid(pin_valid),
        .digit_cnt(digit_cnt),
        .entry_err(entry_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one-cycle strobe driven at negedge; returns #1 after the capturing edge
    task automatic press(input logic v, input logic [3:0] d, input logic e, input logic c);
        @(negedge clock);
        key_valid = v;
        key_digit = d;
        key_enter = e;
        key_clear = c;
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_enter = 1'b0;
        key_clear = 1'b0;
    endtask

    task automatic digit(input logic [3:0] d);
        press(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic enter();
        press(1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int n;

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        pin_ready = 1'b0;
        #3;
        chk("rst_value", int'(pin_value), 0);
        chk("rst_valid", int'(pin_valid), 0);
        chk("rst_cnt",   int'(digit_cnt), 0);
        chk("rst_err",   int'(entry_err), 0);
        @(negedge clock);
        reset = 1'b0;

        // 7,2,enter with ready high: one-cycle valid
        pin_ready = 1'b1;
        digit(4'd7);
        chk("t1_cnt1", int'(digit_cnt), 1);
        digit(4'd2);
        chk("t1_cnt2", int'(digit_cnt), 2);
        enter();
        chk("t1_valid", int'(pin_valid), 1);
        chk("t1_value", int'(pin_value), 72);
        tick();
        chk("t1_valid_drop", int'(pin_valid), 0);
        chk("t1_cnt_clr",    int'(digit_cnt), 0);

        // backpressure: valid held 6 cycles, value stable
        pin_ready = 1'b0;
        digit(4'd7);
        digit(4'd2);
        enter();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            pin_ready = (i == 5);
            chk("t2_valid_hold", int'(pin_valid), 1);
            chk("t2_value_hold", int'(pin_value), 72);
            @(posedge clock);
            #1;
        end
        chk("t2_valid_drop", int'(pin_valid), 0);

        // early enter
        digit(4'd7);
        enter();
        chk("t3_err",   int'(entry_err), 1);
        chk("t3_valid", int'(pin_valid), 0);
        chk("t3_cnt",   int'(digit_cnt), 0);
        tick();
        chk("t3_err_1cyc", int'(entry_err), 0);
        digit(4'd1);
        digit(4'd5);
        enter();
        chk("t3_value", int'(pin_value), 15);
        chk("t3_valid2", int'(pin_valid), 1);
        tick();

        // illegal digit, then extra digit in FULL ignored
        digit(4'd12);
        chk("t4_err", int'(entry_err), 1);
        chk("t4_cnt", int'(digit_cnt), 0);
        digit(4'd7);
        chk("t4_err_1cyc", int'(entry_err), 0);
        digit(4'd2);
        digit(4'd9);
        chk("t4_cnt_full", int'(digit_cnt), 2);
        chk("t4_no_err",   int'(entry_err), 0);
        digit(4'd15);
        chk("t4_full_bad_err", int'(entry_err), 1);
        chk("t4_full_bad_cnt", int'(digit_cnt), 2);
        enter();
        chk("t4_value", int'(pin_value), 72);
        tick();

        // timeout after TIMEOUT_CYCLES idle cycles
        digit(4'd7);
        n = 0;
        while (entry_err == 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_timeout_cycles", n, int'(TIMEOUT_CYCLES));
        chk("t5_cnt", int'(digit_cnt), 0);
        chk("t5_valid", int'(pin_valid), 0);

        // clear beats enter in FULL
        digit(4'd3);
        digit(4'd4);
        press(1'b0, 4'd0, 1'b1, 1'b1);
        chk("t5_clr_valid", int'(pin_valid), 0);
        chk("t5_clr_err",   int'(entry_err), 0);
        chk("t5_clr_cnt",   int'(digit_cnt), 0);
        tick();
        chk("t5_clr_valid2", int'(pin_valid), 0);
        digit(4'd5);
        chk("t5_idle_cnt", int'(digit_cnt), 1);
        press(1'b0, 4'd0, 1'b0, 1'b1);

        // async reset while presenting
        pin_ready = 1'b0;
        digit(4'd8);
        digit(4'd1);
        enter();
        chk("t6_valid_pre", int'(pin_valid), 1);
        chk("t6_value_pre", int'(pin_value), 81);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", int'(pin_valid), 0);
        chk("t6_rst_value", int'(pin_value), 0);
        chk("t6_rst_cnt",   int'(digit_cnt), 0);
        chk("t6_rst_err",   int'(entry_err), 0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("t6_post_valid", int'(pin_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
